// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: framed MSB-first serial word receiver.
// The receiver rebuilds WIDTH-bit samples from a serial stream. Frame_start marks
// the MSB bit time. A word that completes raises Word_valid for one cycle. A word
// that is cut short by a new Frame_start raises Frame_err for one cycle and
// increments a saturating error counter.
module sipo_frame_rx #(
   parameter int WIDTH = 12,
   parameter int ERR_W = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Ser_in,
   input  logic             Frame_start,
   output logic [WIDTH-1:0] Par_out,
   output logic             Word_valid,
   output logic             Busy,
   output logic             Frame_err,
   output logic [ERR_W-1:0] Err_cnt
);

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_nxt;
   // The top bit of a completed word is already in the shift register when the
   // last bit arrives. For that reason, WIDTH-1 stored bits are enough.
   logic [WIDTH-2:0]   shift_q, shift_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [WIDTH-1:0]   par_nxt;
   logic               wv_nxt, fe_nxt;
   logic [ERR_W-1:0]   err_nxt;

   // Next-state and datapath decode. Frame_start always wins: in SHIFT it aborts
   // the current word, and the new bit becomes the MSB of the next word.
   always_comb begin
      state_nxt = state_q;
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
      par_nxt   = Par_out;
      wv_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      err_nxt   = Err_cnt;
      case (state_q)
         IDLE: begin
            if (Frame_start) begin
               shift_nxt = (WIDTH-1)'(Ser_in);
               cnt_nxt   = CNT_W'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (Frame_start) begin
               fe_nxt    = 1'b1;
               if (Err_cnt != {ERR_W{1'b1}}) err_nxt = Err_cnt + ERR_W'(1);
               shift_nxt = (WIDTH-1)'(Ser_in);
               cnt_nxt   = CNT_W'(1);
            end else if (cnt_q == LAST) begin
               par_nxt   = {shift_q, Ser_in};
               wv_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               shift_nxt = (WIDTH-1)'({shift_q, Ser_in});
               cnt_nxt   = cnt_q + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers. All outputs come from flops, including Busy.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         Par_out    <= '0;
         Word_valid <= 1'b0;
         Busy       <= 1'b0;
         Frame_err  <= 1'b0;
         Err_cnt    <= '0;
      end else begin
         state_q    <= state_nxt;
         shift_q    <= shift_nxt;
         cnt_q      <= cnt_nxt;
         Par_out    <= par_nxt;
         Word_valid <= wv_nxt;
         Busy       <= (state_nxt == SHIFT);
         Frame_err  <= fe_nxt;
         Err_cnt    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx. Stimulus is driven on negedge, the same way the PISO
// transmitter drives it. Expected words go into a queue when they are sent. They
// are popped when Word_valid is seen. A second instance with ERR_W=2 shares the
// inputs so that counter saturation can be observed.
module tb_sipo_frame_rx;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Ser_in;
   logic        Frame_start;
   logic [11:0] Par_out;
   logic        Word_valid, Busy, Frame_err;
   logic [7:0]  Err_cnt;
   logic [11:0] par2;
   logic        wv2, busy2, fe2;
   logic [1:0]  err2;

   sipo_frame_rx #(.WIDTH(12), .ERR_W(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Ser_in(Ser_in), .Frame_start(Frame_start),
      .Par_out(Par_out), .Word_valid(Word_valid), .Busy(Busy),
      .Frame_err(Frame_err), .Err_cnt(Err_cnt));

   sipo_frame_rx #(.WIDTH(12), .ERR_W(2)) dut2 (
      .Clk(Clk), .Rst_n(Rst_n), .Ser_in(Ser_in), .Frame_start(Frame_start),
      .Par_out(par2), .Word_valid(wv2), .Busy(busy2),
      .Frame_err(fe2), .Err_cnt(err2));

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   logic [11:0] exp_q[$];
   int fe_seen = 0;
   int fe_exp  = 0;
   int err_exp = 0;
   int err2_exp = 0;
   logic m_busy = 1'b0;
   int   m_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one bit time. Also track the frame state that a correct receiver
   // would have, so that aborts and the resulting counts are known.
   task automatic drv(input logic s, input logic fs);
      @(negedge Clk);
      Ser_in = s;
      Frame_start = fs;
      if (fs) begin
         if (m_busy) begin
            fe_exp++;
            if (err_exp  != 255) err_exp++;
            if (err2_exp != 3)   err2_exp++;
         end
         m_busy = 1'b1;
         m_cnt  = 1;
      end else if (m_busy) begin
         if (m_cnt == 11) m_busy = 1'b0;
         else m_cnt++;
      end
   endtask

   task automatic send(input logic [11:0] w);
      for (int i = 11; i >= 0; i--) drv(w[i], i == 11);
      exp_q.push_back(w);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'($urandom), 1'b0);
   endtask

   // Output monitor: every Word_valid pulse must match the oldest word that was sent.
   always @(negedge Clk) begin
      if (Word_valid) begin
         if (exp_q.size() == 0) chk("wv_unexpected", {31'b0, Word_valid}, 32'd0);
         else chk("par_out", {20'b0, Par_out}, {20'b0, exp_q.pop_front()});
      end
      if (Frame_err) fe_seen++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] w;
      logic [1:0]  sat_seq [5];
      int fe_before;
      sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      Rst_n = 1'b0; Ser_in = 1'b0; Frame_start = 1'b0;
      #1;
      chk("rst_par",  {20'b0, Par_out}, 0);
      chk("rst_wv",   {31'b0, Word_valid}, 0);
      chk("rst_busy", {31'b0, Busy}, 0);
      chk("rst_fe",   {31'b0, Frame_err}, 0);
      chk("rst_err",  {24'b0, Err_cnt}, 0);
      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;

      // 1) single word with cycle-exact Busy / Word_valid timing
      w = 12'hA5C;
      for (int k = 0; k < 12; k++) begin
         drv(w[11-k], k == 0);
         if (k == 11) exp_q.push_back(w);
         @(posedge Clk); #1;
         chk("t1_busy", {31'b0, Busy}, (k < 11) ? 32'd1 : 32'd0);
         chk("t1_wv",   {31'b0, Word_valid}, (k == 11) ? 32'd1 : 32'd0);
      end
      idle(1);
      @(posedge Clk); #1;
      chk("t1_wv_off", {31'b0, Word_valid}, 0);
      chk("t1_par_hold", {20'b0, Par_out}, 32'hA5C);

      // 2) back-to-back words
      send(12'hFFF); send(12'h001); send(12'h800);
      idle(3);
      chk("t2_fe", fe_seen, fe_exp);

      // 3) abort after 5 bits, then a good word
      drv(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) drv(1'($urandom), 1'b0);
      send(12'h3C3);
      idle(3);
      chk("t3_fe", fe_seen, fe_exp);
      chk("t3_err", {24'b0, Err_cnt}, err_exp);
      chk("t3_err_is1", {24'b0, Err_cnt}, 32'd1);

      // 4) reset in the middle of a word
      drv(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) drv(1'($urandom), 1'b0);
      @(negedge Clk);
      Rst_n = 1'b0;
      m_busy = 1'b0; err_exp = 0; err2_exp = 0;
      #1;
      chk("t4_par",  {20'b0, Par_out}, 0);
      chk("t4_busy", {31'b0, Busy}, 0);
      chk("t4_err",  {24'b0, Err_cnt}, 0);
      chk("t4_wv",   {31'b0, Word_valid}, 0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      fe_before = fe_seen;
      send(12'h123);
      idle(3);
      chk("t4_fe", fe_seen - fe_before, 0);

      // 5) repeated aborts: 2-bit counter saturates, 8-bit counter keeps counting
      drv(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) drv(1'($urandom), 1'b0);
      for (int a = 0; a < 5; a++) begin
         drv(1'($urandom), 1'b1);
         @(posedge Clk); #1;
         chk("t5_err2", {30'b0, err2}, {30'b0, sat_seq[a]});
         chk("t5_fe",   {31'b0, Frame_err}, 1);
         chk("t5_err8", {24'b0, Err_cnt}, err_exp);
         for (int i = 0; i < 2; i++) drv(1'($urandom), 1'b0);
      end
      send(12'h5A5);
      idle(3);
      chk("t5_fe_total", fe_seen, fe_exp);
      chk("t5_err2_end", {30'b0, err2}, err2_exp);

      // 6) loopback: 1000 random words, with occasional idle gaps
      fe_before = fe_seen;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
         send(12'($urandom));
      end
      idle(3);
      chk("t6_fe", fe_seen - fe_before, 0);
      chk("t6_err", {24'b0, Err_cnt}, err_exp);
      chk("q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
